seq_det_ctrl: RTL and testbench

Programmable overlapping Moore sequence-detector controller. Software or an upstream FSM loads a pattern (1..PW bits), a target match count and an optional timeout, then starts a scan. The block shifts the serial `signal` stream through a detection window, counts overlapping matches, and terminates on target reached, timeout or abort. It sequences and configures the fixed-pattern detectors in the FSM collection so that a single instance serves any pattern up to PW bits.

---
 rtl/seq_det_ctrl.sv | 159 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable overlapping Moore sequence detector: loads a 1..PW bit pattern,
// scans the serial stream and stops on target match count, timeout or abort.
module seq_det_ctrl #(
   parameter int PW = 8,
   parameter int LW = 4,
   parameter int CW = 8,
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [PW-1:0] pat,
   input  logic [LW-1:0] len,
   input  logic [CW-1:0] target,
   input  logic [TW-1:0] timeout,
   input  logic          signal,
   input  logic          sig_valid,
   output logic          busy,
   output logic          hit,
   output logic [CW-1:0] match_cnt,
   output logic          done,
   output logic          timed_out,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [LW-1:0] PW_L = LW'(PW);

   state_t        state_reg, state_next;
   logic [PW-1:0] window_reg, window_next;
   logic [PW-1:0] pat_reg, pat_next;
   logic [LW-1:0] fill_reg, fill_next;
   logic [LW-1:0] len_reg, len_next;
   logic [CW-1:0] target_reg, target_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic [TW-1:0] tcnt_reg, tcnt_next;
   logic          hit_reg, hit_next;
   logic          err_reg, err_next;
   logic          to_reg, to_next;

   logic [PW-1:0] mask;
   logic [PW-1:0] shifted;
   logic [LW-1:0] fill_inc;
   logic [CW-1:0] cnt_inc;
   logic          match;

   // Only the low len_reg bits of the window take part in the compare.
   generate
      for (genvar gi = 0; gi < PW; gi++) begin : g_mask
         assign mask[gi] = (LW'(gi) < len_reg);
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      window_next = window_reg;
      pat_next    = pat_reg;
      fill_next   = fill_reg;
      len_next    = len_reg;
      target_next = target_reg;
      cnt_next    = cnt_reg;
      tmo_next    = tmo_reg;
      tcnt_next   = tcnt_reg;
      to_next     = to_reg;
      hit_next    = 1'b0;
      err_next    = 1'b0;
      match       = 1'b0;
      shifted     = {window_reg[PW-2:0], signal};
      fill_inc    = (fill_reg == PW_L) ? fill_reg : fill_reg + 1'b1;
      cnt_inc     = cnt_reg + 1'b1;

      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (len == '0 || len > PW_L || target == '0) begin
                     err_next = 1'b1;
                  end else begin
                     pat_next    = pat;
                     len_next    = len;
                     target_next = target;
                     tmo_next    = timeout;
                     window_next = '0;
                     fill_next   = '0;
                     cnt_next    = '0;
                     tcnt_next   = '0;
                     to_next     = 1'b0;
                     state_next  = SCAN;
                  end
               end
            end
            SCAN: begin
               tcnt_next = tcnt_reg + 1'b1;
               if (sig_valid) begin
                  window_next = shifted;
                  fill_next   = fill_inc;
                  match       = (fill_inc >= len_reg) && ((shifted & mask) == (pat_reg & mask));
               end
               if (match) begin
                  hit_next = 1'b1;
                  cnt_next = cnt_inc;
               end
               // Reaching the target wins over a timeout on the same edge.
               if (match && cnt_inc == target_reg) begin
                  state_next = DONE;
               end else if (tmo_reg != '0 && tcnt_reg == tmo_reg - 1'b1) begin
                  to_next    = 1'b1;
                  state_next = DONE;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         window_reg <= '0;
         pat_reg    <= '0;
         fill_reg   <= '0;
         len_reg    <= '0;
         target_reg <= '0;
         cnt_reg    <= '0;
         tmo_reg    <= '0;
         tcnt_reg   <= '0;
         hit_reg    <= 1'b0;
         err_reg    <= 1'b0;
         to_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         window_reg <= window_next;
         pat_reg    <= pat_next;
         fill_reg   <= fill_next;
         len_reg    <= len_next;
         target_reg <= target_next;
         cnt_reg    <= cnt_next;
         tmo_reg    <= tmo_next;
         tcnt_reg   <= tcnt_next;
         hit_reg    <= hit_next;
         err_reg    <= err_next;
         to_reg     <= to_next;
      end
   end

   assign busy      = (state_reg == SCAN);
   assign done      = (state_reg == DONE);
   assign hit       = hit_reg;
   assign err       = err_reg;
   assign timed_out = to_reg;
   assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random scans, every cycle
// compared against a bit-history reference model.
module tb_seq_det_ctrl;

   localparam int PW = 8;
   localparam int LW = 4;
   localparam int CW = 8;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst, start, abort, signal, sig_valid;
   logic [PW-1:0] pat;
   logic [LW-1:0] len;
   logic [CW-1:0] target;
   logic [TW-1:0] timeout;
   logic          busy, hit, done, timed_out, err;
   logic [CW-1:0] match_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_det_ctrl #(.PW(PW), .LW(LW), .CW(CW), .TW(TW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pat(pat), .len(len), .target(target), .timeout(timeout),
      .signal(signal), .sig_valid(sig_valid),
      .busy(busy), .hit(hit), .match_cnt(match_cnt), .done(done),
      .timed_out(timed_out), .err(err)
   );

   // Reference model: phase 0 idle, 1 scanning, 2 finished.
   int  m_phase = 0, m_cnt = 0, m_elapsed = 0, m_len = 0, m_target = 0, m_tmo = 0, m_pat = 0;
   bit  m_hit = 0, m_err = 0, m_to = 0;
   bit  hist[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit hist_match();
      int v = 0;
      if (hist.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++)
         v = (v << 1) | int'(hist[hist.size() - m_len + i]);
      return v == (m_pat & ((1 << m_len) - 1));
   endfunction

   task automatic model_edge();
      bit matched;
      m_hit = 0;
      m_err = 0;
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_to = 0;
      end else if (abort) begin
         m_phase = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            if (len == 0 || int'(len) > PW || target == 0) begin
               m_err = 1;
            end else begin
               m_pat = int'(pat); m_len = int'(len); m_target = int'(target); m_tmo = int'(timeout);
               hist.delete();
               m_cnt = 0; m_to = 0; m_elapsed = 0; m_phase = 1;
            end
         end
      end else if (m_phase == 1) begin
         matched = 0;
         m_elapsed++;
         if (sig_valid) begin
            hist.push_back(signal);
            if (hist.size() > PW) void'(hist.pop_front());
            matched = hist_match();
         end
         if (matched) begin
            m_hit = 1;
            m_cnt++;
         end
         if (matched && m_cnt == m_target) begin
            m_phase = 2;
         end else if (m_tmo != 0 && m_elapsed == m_tmo) begin
            m_phase = 2;
            m_to = 1;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_val("busy", busy, m_phase == 1);
      check_val("done", done, m_phase == 2);
      check_val("hit", hit, m_hit);
      check_val("err", err, m_err);
      check_val("timed_out", timed_out, m_to);
      check_val("match_cnt", match_cnt, m_cnt);
   endtask

   task automatic begin_scan(input int p, input int l, input int t, input int tmo);
      pat = PW'(p); len = LW'(l); target = CW'(t); timeout = TW'(tmo);
      $display("start pat=%0h len=%0d target=%0d timeout=%0d", p, l, t, tmo);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic feed(input bit b, input bit v);
      signal = b;
      sig_valid = v;
      step();
      sig_valid = 1'b0;
      signal = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; signal = 1'b0; sig_valid = 1'b0;
      pat = '0; len = '0; target = '0; timeout = '0;
      step();
      step();
      rst = 1'b0;
      step();

      // Overlapping 101 on 10101: hits after bits 3 and 5, done with the second.
      begin_scan(5, 3, 2, 0);
      feed(1, 1); feed(0, 1); feed(1, 1); feed(0, 1); feed(1, 1);
      check_val("ovl_done_hit", {done, hit}, 2'b11);
      step();
      check_val("ovl_final_cnt", match_cnt, 2);

      // Valid gating: ones on invalid cycles must not count.
      begin_scan(5, 3, 1, 0);
      feed(1, 1); feed(1, 0); feed(0, 1); feed(1, 0); feed(1, 1);
      check_val("gate_done", done, 1);
      step();

      // Timeout after exactly 10 scan cycles.
      begin_scan(15, 4, 1, 10);
      repeat (10) feed(0, 1);
      check_val("tmo_flag", {done, timed_out}, 2'b11);
      step();

      // Bad configurations.
      begin_scan(5, 0, 1, 0);
      step();
      begin_scan(5, 9, 1, 0);
      step();
      begin_scan(5, 3, 0, 0);
      step();

      // Final match on the last timeout cycle counts as success.
      begin_scan(5, 3, 1, 3);
      feed(1, 1); feed(0, 1); feed(1, 1);
      check_val("edge_success", {done, timed_out, hit}, 3'b101);
      step();

      // Abort on the edge of a would-be match.
      begin_scan(5, 3, 3, 0);
      feed(1, 1); feed(0, 1);
      abort = 1'b1; signal = 1'b1; sig_valid = 1'b1;
      step();
      abort = 1'b0; sig_valid = 1'b0;
      check_val("abort_idle", {busy, hit, done}, 3'b000);
      step();

      // Reset mid-scan with two matches counted.
      begin_scan(5, 3, 5, 0);
      feed(1, 1); feed(0, 1); feed(1, 1); feed(0, 1); feed(1, 1);
      check_val("pre_rst_cnt", match_cnt, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      // Random scans, with config churn, stray starts and rare aborts mid-scan.
      for (int n = 0; n < 40; n++) begin
         int cyc;
         begin_scan(int'($urandom_range(0, 255)), int'($urandom_range(0, 9)),
                    int'($urandom_range(1, 4)),
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40)));
         cyc = 0;
         while (m_phase != 0 && cyc < 150) begin
            signal    = 1'($urandom_range(0, 1));
            sig_valid = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 199) == 0);
            pat       = PW'($urandom_range(0, 255));
            len       = LW'($urandom_range(0, 15));
            step();
            cyc++;
         end
         start = 1'b0; sig_valid = 1'b0;
         if (m_phase != 0) begin
            abort = 1'b1;
            step();
         end
         abort = 1'b0;
         step();
         $display("scan %0d ended cnt=%0d timed_out=%0d cycles=%0d", n, m_cnt, m_to, cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
